// File: rtl/uart_tx_periph.sv
// uart_tx_periph
// Memory-mapped 8N1 UART transmitter for the RV32i data-memory bus.
// Firmware writes bytes to TXDATA. They are queued in a small FIFO and
// shifted out LSB first on tx_o. STATUS reports busy/full/empty/overflow
// and the FIFO level.
//
// Ports:
//   clk_i    - single clock, rising edge
//   reset_i  - synchronous active-high reset
//   cs_i     - chip select from address decode
//   we_i     - write strobe
//   re_i     - read strobe
//   ble_i    - byte-lane enables (only lane 0 is used)
//   add_i    - byte address; add_i[3:2] selects the register
//   d_i      - write data
//   d_o      - registered read data (1-cycle latency, 0 when not reading)
//   tx_o     - serial line, idles high
//
// Register map (word offset):
//   0 TXDATA  write pushes d_i[7:0]; reads return 0
//   1 STATUS  {16'h0, level[7:0], 4'h0, overflow, empty, full, busy}
//             writing with d_i[3]=1 clears overflow
//   2,3       reserved

module uart_tx_periph #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cs_i,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [3:0]  ble_i,
    input  logic [3:0]  add_i,
    input  logic [31:0] d_i,
    output logic [31:0] d_o,
    output logic        tx_o
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_ovf;

    // Transmitter
    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_tx;

    // Read port
    logic [31:0]   r_rdata;

    logic          w_wr_lane0;
    logic          w_rd;
    logic          w_full;
    logic          w_empty;
    logic          w_busy;
    logic          w_push_req;
    logic          w_push;
    logic          w_pop;
    logic          w_ovf_clr;
    logic [31:0]   w_status;
    logic [31:0]   w_rd_mux;
    logic          w_unused;

    assign w_wr_lane0 = cs_i & we_i & ble_i[0];
    assign w_rd       = cs_i & re_i;

    // Full/empty come from the pre-edge level, so a push into a full FIFO
    // is dropped even when the transmitter pops on the same edge, and a
    // push into an empty FIFO is only popped on the following edge.
    assign w_full     = (r_level == LEVEL_FULL);
    assign w_empty    = (r_level == {LW{1'b0}});
    assign w_busy     = (r_state != ST_IDLE);
    assign w_push_req = w_wr_lane0 & (add_i[3:2] == 2'd0);
    assign w_push     = w_push_req & ~w_full;
    assign w_pop      = (r_state == ST_IDLE) & ~w_empty;
    assign w_ovf_clr  = w_wr_lane0 & (add_i[3:2] == 2'd1) & d_i[3];

    // Level is narrower than 8 bits for any practical depth; zero-extend it.
    assign w_status = {16'h0000, 8'(r_level), 4'h0, r_ovf, w_empty, w_full, w_busy};

    // Bits that the register map never looks at
    assign w_unused = ^{add_i[1:0], ble_i[3:1], d_i[31:8]};

    // Read-data select for the addressed register
    always_comb begin
        w_rd_mux = 32'h0000_0000;
        case (add_i[3:2])
            2'd1:    w_rd_mux = w_status;
            default: w_rd_mux = 32'h0000_0000;
        endcase
    end

    // FIFO pointers, level counter and sticky overflow flag
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_level <= {LW{1'b0}};
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
            // A dropped push wins over a same-cycle clear so the loss is seen
            if (w_push_req & w_full) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

    // FIFO data array (contents need no reset; level gates every read)
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= d_i[7:0];
        end
    end

    // Transmit FSM; tx_o is registered from the current state, so the line
    // lags the state by one cycle and frame lengths stay exact.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state  <= ST_IDLE;
            r_baud   <= {BW{1'b0}};
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
            r_tx     <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift  <= r_mem[r_rptr];
                        r_bitcnt <= 3'd0;
                        r_baud   <= {BW{1'b0}};
                        r_state  <= ST_START;
                    end
                end
                ST_START: begin
                    r_tx <= 1'b0;
                    if (r_baud == BAUD_LAST) begin
                        r_baud  <= {BW{1'b0}};
                        r_state <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                ST_DATA: begin
                    r_tx <= r_shift[0];
                    if (r_baud == BAUD_LAST) begin
                        r_baud  <= {BW{1'b0}};
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bitcnt == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                ST_STOP: begin
                    r_tx <= 1'b1;
                    if (r_baud == BAUD_LAST) begin
                        r_baud  <= {BW{1'b0}};
                        r_state <= ST_IDLE;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_baud  <= {BW{1'b0}};
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered read port: loads the selected register when read, else 0
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rdata <= 32'h0000_0000;
        end else if (w_rd) begin
            r_rdata <= w_rd_mux;
        end else begin
            r_rdata <= 32'h0000_0000;
        end
    end

    assign d_o  = r_rdata;
    assign tx_o = r_tx;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph.
// A timeline model predicts tx_o and d_o every cycle for a fast-baud
// instance; a serial receiver checks a second instance at 217 clocks/bit.

module tb_uart_tx_periph;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int CPB2  = 217;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        cs_i = 1'b0, we_i = 1'b0, re_i = 1'b0;
    logic [3:0]  ble_i = 4'h0, add_i = 4'h0;
    logic [31:0] d_i = 32'h0;
    logic [31:0] d_o;
    logic        tx_o;

    logic        cs2 = 1'b0, we2 = 1'b0, re2 = 1'b0;
    logic [3:0]  ble2 = 4'h0, add2 = 4'h0;
    logic [31:0] d2_i = 32'h0;
    logic [31:0] d2_o;
    logic        tx2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    uart_tx_periph #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .cs_i(cs_i), .we_i(we_i), .re_i(re_i),
        .ble_i(ble_i), .add_i(add_i), .d_i(d_i), .d_o(d_o), .tx_o(tx_o)
    );

    uart_tx_periph #(.CLKS_PER_BIT(CPB2), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk_i(clk_i), .reset_i(reset_i), .cs_i(cs2), .we_i(we2), .re_i(re2),
        .ble_i(ble2), .add_i(add2), .d_i(d2_i), .d_o(d2_o), .tx_o(tx2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model of the fast instance ----------------
    // A frame popped at edge S puts frame bit (k / CPB) on the line after
    // edge S+1+k for k in 0..10*CPB-1; the transmitter may pop again at
    // edge S+10*CPB+1. Frame bits: 0, data LSB first, 1.
    logic [7:0]  m_q[$];
    logic        m_ovf = 1'b0;
    logic        m_ok = 1'b0;
    int          m_cyc = 0;
    int          m_start = -100000;
    logic [7:0]  m_byte = 8'h00;
    logic        exp_tx = 1'b1;
    logic [31:0] exp_do = 32'h0;

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[idx-1];
        else return 1'b1;
    endfunction

    always @(posedge clk_i) begin
        int   off;
        logic busy_pre, full_pre, empty_pre;
        m_cyc++;
        if (reset_i) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_start = -100000;
            exp_tx  = 1'b1;
            exp_do  = 32'h0;
            m_ok    = 1'b1;
        end else if (m_ok) begin
            off       = m_cyc - 1 - m_start;
            busy_pre  = (off >= 0) && (off < 10 * CPB);
            full_pre  = (m_q.size() == DEPTH);
            empty_pre = (m_q.size() == 0);
            exp_tx    = busy_pre ? frame_bit(m_byte, off / CPB) : 1'b1;
            if (cs_i && re_i && add_i[3:2] == 2'd1)
                exp_do = {16'h0, 8'(m_q.size()), 4'h0, m_ovf, empty_pre, full_pre, busy_pre};
            else
                exp_do = 32'h0;
            if (!busy_pre && !empty_pre) begin
                m_byte  = m_q.pop_front();
                m_start = m_cyc;
            end
            if (cs_i && we_i && ble_i[0] && add_i[3:2] == 2'd0) begin
                if (full_pre) m_ovf = 1'b1;
                else m_q.push_back(d_i[7:0]);
            end
            if (cs_i && we_i && ble_i[0] && add_i[3:2] == 2'd1 && d_i[3])
                m_ovf = 1'b0;
        end
    end

    // Per-cycle compare on the falling edge; also counts line falls
    logic tx_prev = 1'b1;
    int   falls = 0;
    always @(negedge clk_i) begin
        if (m_ok) begin
            check("tx_line", {31'h0, tx_o}, {31'h0, exp_tx});
            check("read_data", d_o, exp_do);
            if (tx_prev && !tx_o) falls++;
        end
        tx_prev = tx_o;
    end

    // ---------------- receiver for the 217-clock instance ----------------
    logic [7:0] rx_exp[$];
    int         rx_got = 0;
    initial begin : rx
        logic [7:0] b;
        logic       prev2;
        prev2 = 1'b1;
        forever begin
            @(negedge clk_i);
            if (prev2 === 1'b1 && tx2 === 1'b0) begin
                repeat (CPB2 / 2) @(negedge clk_i);
                check("rx_start", {31'h0, tx2}, 32'h0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB2) @(negedge clk_i);
                    b[i] = tx2;
                end
                repeat (CPB2) @(negedge clk_i);
                check("rx_stop", {31'h0, tx2}, 32'h1);
                if (rx_exp.size() == 0) check("rx_unexpected", {24'h0, b}, 32'hFFFF_FFFF);
                else check("rx_byte", {24'h0, b}, {24'h0, rx_exp.pop_front()});
                rx_got++;
            end
            prev2 = tx2;
        end
    end

    // ---------------- stimulus ----------------
    task automatic acc(input logic cs, input logic we, input logic re,
                       input logic [3:0] ble, input logic [3:0] add, input logic [31:0] d);
        cs_i = cs; we_i = we; re_i = re; ble_i = ble; add_i = add; d_i = d;
        @(negedge clk_i);
        cs_i = 1'b0; we_i = 1'b0; re_i = 1'b0; ble_i = 4'h0; add_i = 4'h0; d_i = 32'h0;
    endtask

    task automatic wr(input logic [7:0] b);
        acc(1'b1, 1'b1, 1'b0, 4'h1, 4'h0, {24'h0, b});
    endtask

    task automatic rd_status(input string name, input logic [31:0] exp);
        acc(1'b1, 1'b0, 1'b1, 4'hF, 4'h4, 32'h0);
        check(name, d_o, exp);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin : main
        logic [9:0] frame;
        logic [7:0] rb;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        check("reset_tx", {31'h0, tx_o}, 32'h1);
        check("reset_do", d_o, 32'h0);
        rd_status("reset_status", 32'h0000_0004);

        // 0xA5 frame at 4 clocks/bit, busy read mid-frame
        wr(8'hA5);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int j = 1; j <= 41; j++) begin
            if (j == 20) begin cs_i = 1'b1; re_i = 1'b1; add_i = 4'h4; end
            @(negedge clk_i);
            if (j == 20) begin
                cs_i = 1'b0; re_i = 1'b0; add_i = 4'h0;
                check("a5_busy_status", d_o, 32'h0000_0005);
            end
            if (j >= 2) check("a5_bit", {31'h0, tx_o}, {31'h0, frame[(j - 2) / CPB]});
            else check("a5_pre", {31'h0, tx_o}, 32'h1);
        end
        rd_status("a5_done_status", 32'h0000_0004);

        // three back-to-back bytes, level 2 -> 1 -> 0
        wr(8'h01); wr(8'h02); wr(8'h03);
        rd_status("lvl2", 32'h0000_0201);
        wait_n(45);
        rd_status("lvl1", 32'h0000_0101);
        wait_n(40);
        rd_status("lvl0", 32'h0000_0005);
        wait_n(40);
        rd_status("three_done", 32'h0000_0004);

        // overflow: 10 writes from idle -> 1 in flight + 8 queued
        falls = 0;
        for (int i = 0; i < 10; i++) wr(8'hFF);
        rd_status("ovf_full", 32'h0000_080B);
        acc(1'b1, 1'b1, 1'b0, 4'h1, 4'h4, 32'h0000_0008);
        rd_status("ovf_cleared", 32'h0000_0803);
        wait_n(400);
        check("ovf_frames", 32'(falls), 32'd9);
        rd_status("ovf_done", 32'h0000_0004);

        // accesses that must not push or return data
        falls = 0;
        acc(1'b0, 1'b1, 1'b1, 4'hF, 4'h0, 32'h55);
        check("cs0_read", d_o, 32'h0);
        acc(1'b0, 1'b0, 1'b1, 4'hF, 4'h4, 32'h0);
        check("cs0_status", d_o, 32'h0);
        acc(1'b1, 1'b1, 1'b0, 4'hE, 4'h0, 32'h66);
        acc(1'b1, 1'b1, 1'b1, 4'hF, 4'h8, 32'h77);
        check("off2_read", d_o, 32'h0);
        acc(1'b1, 1'b1, 1'b1, 4'hF, 4'hC, 32'h88);
        check("off3_read", d_o, 32'h0);
        acc(1'b1, 1'b0, 1'b1, 4'hF, 4'h0, 32'h0);
        check("txdata_read", d_o, 32'h0);
        wait_n(10);
        check("nopush_falls", 32'(falls), 32'd0);
        rd_status("nopush_status", 32'h0000_0004);

        // reset mid-DATA with 3 bytes queued
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
        wait_n(15);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        check("midreset_tx", {31'h0, tx_o}, 32'h1);
        check("midreset_do", d_o, 32'h0);
        rd_status("midreset_status", 32'h0000_0004);
        falls = 0;
        wait_n(100);
        check("midreset_falls", 32'(falls), 32'd0);

        // random stream at 217 clocks/bit through the receiver
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom_range(0, 255));
            rx_exp.push_back(rb);
            cs2 = 1'b1; we2 = 1'b1; ble2 = 4'h1; add2 = 4'h0; d2_i = {24'h0, rb};
            @(negedge clk_i);
            cs2 = 1'b0; we2 = 1'b0; ble2 = 4'h0; d2_i = 32'h0;
        end
        for (int t = 0; t < 15000 && rx_got < 6; t++) @(negedge clk_i);
        check("rx_count", 32'(rx_got), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
